// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset/exception vectors, opcodes, and the PC unit state encoding.
package cpu_pkg;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0008;

   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } pc_state_t;
endpackage

// File: rtl/if_target_calc.sv
// Combinational next-PC candidates: sequential, IF-stage branch target, ID-stage jump target.
// Zero latency; no flow control.
module if_target_calc (
   input  logic [31:0] pc,
   input  logic [15:0] offset,
   input  logic [31:0] id_pc_plus4,
   input  logic [25:0] instr_index,
   output logic [31:0] seq,
   output logic [31:0] btgt,
   output logic [31:0] jtgt
);
   assign seq  = pc + 32'd4;
   assign btgt = seq + {{14{offset[15]}}, offset, 2'b00};
   assign jtgt = {id_pc_plus4[31:28], instr_index, 2'b00};
endmodule

// File: rtl/if_pc_redirect.sv
// IF-stage PC register and IF/ID PC fields with static taken prediction, ID corrections and exception redirect.
// Redirects land one cycle later (one bubble); stall holds PC and IF/ID fields.
module if_pc_redirect
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] if_instr,
   input  logic        if_branch,
   input  logic        id_nbranch,
   input  logic        id_j,
   input  logic        id_jr,
   input  logic [31:0] id_rs,
   input  logic [25:0] id_instr_index,
   input  logic        stall,
   input  logic        exc_req,
   output logic [31:0] pc,
   output logic [31:0] id_pc_plus4,
   output logic        id_pred_taken,
   output logic        id_valid,
   output logic        if_id_flush
);
   pc_state_t   state, state_nxt;
   logic        exc_pend;
   logic        exc_apply, id_redir;
   logic [31:0] seq, btgt, jtgt, id_tgt, pc_nxt;
   logic        unused_instr_hi;

   assign unused_instr_hi = ^if_instr[31:16];

   if_target_calc u_tgt (
      .pc          (pc),
      .offset      (if_instr[15:0]),
      .id_pc_plus4 (id_pc_plus4),
      .instr_index (id_instr_index),
      .seq         (seq),
      .btgt        (btgt),
      .jtgt        (jtgt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= BOOT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (exc_req && stall) state_nxt = HOLD;
         HOLD:    if (!stall) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   // Not-taken recovery only matters if we actually predicted taken.
   always_comb begin
      exc_apply   = (state != BOOT) && !stall && (exc_req || exc_pend);
      id_redir    = (state == RUN) && id_valid && !stall &&
                    ((id_nbranch && id_pred_taken) || id_jr || id_j);
      if_id_flush = exc_apply || id_redir;
      id_tgt      = jtgt;
      if (id_nbranch && id_pred_taken) id_tgt = id_pc_plus4;
      else if (id_jr)                  id_tgt = id_rs;
      pc_nxt = seq;
      if (state == BOOT)  pc_nxt = pc;
      else if (exc_apply) pc_nxt = EXC_VECTOR;
      else if (id_redir)  pc_nxt = id_tgt;
      else if (stall)     pc_nxt = pc;
      else if (if_branch) pc_nxt = btgt;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc            <= RESET_PC;
         id_pc_plus4   <= 32'd0;
         id_pred_taken <= 1'b0;
         id_valid      <= 1'b0;
         exc_pend      <= 1'b0;
      end else begin
         pc <= pc_nxt;
         if (exc_apply)                            exc_pend <= 1'b0;
         else if (state == RUN && exc_req && stall) exc_pend <= 1'b1;
         // First fetch is still in flight during BOOT, so ID stays a bubble.
         if (state != BOOT) begin
            if (if_id_flush) begin
               id_valid      <= 1'b0;
               id_pred_taken <= 1'b0;
            end else if (!stall) begin
               id_pc_plus4   <= seq;
               id_pred_taken <= if_branch;
               id_valid      <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_if_pc_redirect.sv
// Directed-vector bench for if_pc_redirect: boot sequence, prediction, ID redirects, stalls, exceptions, wrap.
module tb_if_pc_redirect;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] if_instr;
   logic        if_branch, id_nbranch, id_j, id_jr, stall, exc_req;
   logic [31:0] id_rs;
   logic [25:0] id_instr_index;
   logic [31:0] pc, id_pc_plus4;
   logic        id_pred_taken, id_valid, if_id_flush;

   int n_vec = 0;
   int n_err = 0;

   if_pc_redirect dut (
      .clock          (clock),
      .reset          (reset),
      .if_instr       (if_instr),
      .if_branch      (if_branch),
      .id_nbranch     (id_nbranch),
      .id_j           (id_j),
      .id_jr          (id_jr),
      .id_rs          (id_rs),
      .id_instr_index (id_instr_index),
      .stall          (stall),
      .exc_req        (exc_req),
      .pc             (pc),
      .id_pc_plus4    (id_pc_plus4),
      .id_pred_taken  (id_pred_taken),
      .id_valid       (id_valid),
      .if_id_flush    (if_id_flush)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      if_instr = 32'd0; if_branch = 1'b0; id_nbranch = 1'b0; id_j = 1'b0;
      id_jr = 1'b0; id_rs = 32'd0; id_instr_index = 26'd0; stall = 1'b0; exc_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick(); tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_pred", {31'd0, id_pred_taken}, 32'd0);
      chk("rst_plus4", id_pc_plus4, 32'h0);
      chk("rst_flush", {31'd0, if_id_flush}, 32'd0);
      reset = 1'b0;

      // Boot: pc 0,0,4,8; first ID slot is a bubble.
      tick(); chk("boot_pc0", pc, 32'h0); chk("boot_valid0", {31'd0, id_valid}, 32'd0);
      tick(); chk("boot_pc4", pc, 32'h4); chk("boot_valid1", {31'd0, id_valid}, 32'd1);
      chk("boot_plus4", id_pc_plus4, 32'h4);
      tick(); chk("boot_pc8", pc, 32'h8);

      // Move to 0x100 via JR.
      id_jr = 1'b1; id_rs = 32'h100; #1;
      chk("jr_flush", {31'd0, if_id_flush}, 32'd1);
      tick(); chk("jr_pc100", pc, 32'h100); chk("jr_valid", {31'd0, id_valid}, 32'd0);
      idle();

      // Predicted-taken branch, then not-taken recovery.
      if_branch = 1'b1; if_instr = 32'h0000_0003;
      tick(); chk("bp_pc", pc, 32'h110); chk("bp_pred", {31'd0, id_pred_taken}, 32'd1);
      chk("bp_plus4", id_pc_plus4, 32'h104); chk("bp_valid", {31'd0, id_valid}, 32'd1);
      idle(); id_nbranch = 1'b1; #1;
      chk("nb_flush", {31'd0, if_id_flush}, 32'd1);
      tick(); chk("nb_pc", pc, 32'h104); chk("nb_valid", {31'd0, id_valid}, 32'd0);
      chk("nb_pred", {31'd0, id_pred_taken}, 32'd0);
      idle();
      tick(); chk("seq_pc108", pc, 32'h108);
      // Not-taken report on an unpredicted instruction is ignored.
      id_nbranch = 1'b1; #1;
      chk("nb_ign_flush", {31'd0, if_id_flush}, 32'd0);
      tick(); chk("nb_ign_pc", pc, 32'h10C);
      idle();

      // J: fetch at 0x8000_003C so ID holds pc_plus4 0x8000_0040.
      id_jr = 1'b1; id_rs = 32'h8000_003C;
      tick(); chk("jr2_pc", pc, 32'h8000_003C);
      idle();
      tick(); chk("j_pre_plus4", id_pc_plus4, 32'h8000_0040);
      id_j = 1'b1; id_instr_index = 26'h0000010;
      tick(); chk("j_pc", pc, 32'h8000_0040); chk("j_valid", {31'd0, id_valid}, 32'd0);
      idle();
      tick(); chk("j_seq", pc, 32'h8000_0044);
      id_jr = 1'b1; id_rs = 32'h2000;
      tick(); chk("jr3_pc", pc, 32'h2000);
      idle();
      tick(); chk("jr3_seq", pc, 32'h2004);

      // Stalled JR: frozen for 3 cycles, then taken once.
      stall = 1'b1; id_jr = 1'b1; id_rs = 32'h3000;
      for (int i = 0; i < 3; i++) begin
         #1; chk("stl_flush", {31'd0, if_id_flush}, 32'd0);
         tick();
         chk("stl_pc", pc, 32'h2004); chk("stl_plus4", id_pc_plus4, 32'h2004);
         chk("stl_valid", {31'd0, id_valid}, 32'd1);
      end
      stall = 1'b0; #1;
      chk("stl_rel_flush", {31'd0, if_id_flush}, 32'd1);
      tick(); chk("stl_rel_pc", pc, 32'h3000);
      idle();
      tick(); chk("stl_once_pc", pc, 32'h3004);

      // Exception under stall: HOLD, repeated pulse absorbed, then vector wins over JR.
      stall = 1'b1; exc_req = 1'b1;
      tick(); chk("hold_pc", pc, 32'h3004); chk("hold_pend", {31'd0, dut.exc_pend}, 32'd1);
      exc_req = 1'b0;
      tick(); chk("hold_pc2", pc, 32'h3004);
      exc_req = 1'b1;
      tick(); chk("hold_pc3", pc, 32'h3004);
      exc_req = 1'b0; stall = 1'b0; id_jr = 1'b1; id_rs = 32'h5000; #1;
      chk("exc_flush", {31'd0, if_id_flush}, 32'd1);
      tick(); chk("exc_pc", pc, 32'h8); chk("exc_pend_clr", {31'd0, dut.exc_pend}, 32'd0);
      chk("exc_valid", {31'd0, id_valid}, 32'd0);
      idle();
      tick(); chk("exc_seq", pc, 32'hC);

      // exc_req together with a mispredict: exception wins.
      if_branch = 1'b1; if_instr = 32'h0000_0004;
      tick(); chk("bp2_pc", pc, 32'h20);
      idle(); exc_req = 1'b1; id_nbranch = 1'b1;
      tick(); chk("exc_nb_pc", pc, 32'h8);
      idle();

      // Branch target wrap below zero.
      tick();
      id_jr = 1'b1; id_rs = 32'h10;
      tick(); chk("wrap_pre", pc, 32'h10);
      idle(); if_branch = 1'b1; if_instr = 32'h0000_8000;
      tick(); chk("wrap_pc", pc, 32'hFFFE_0014);
      idle();

      // Reset while HOLD discards the pending exception.
      stall = 1'b1; exc_req = 1'b1;
      tick(); chk("hold2_pend", {31'd0, dut.exc_pend}, 32'd1);
      exc_req = 1'b0; reset = 1'b1; #1;
      chk("mrst_pc", pc, 32'h0); chk("mrst_pend", {31'd0, dut.exc_pend}, 32'd0);
      chk("mrst_valid", {31'd0, id_valid}, 32'd0);
      tick();
      reset = 1'b0; stall = 1'b0;
      tick(); chk("mrst_boot", pc, 32'h0);
      tick(); chk("mrst_run", pc, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
